paint_canvas: RTL and testbench



---
 rtl/paint_canvas.sv | 166 ++++++++++++++++
 tb/tb_paint_canvas.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/paint_canvas.sv
// Pixel stage over a 160x120 canvas of 3-bit cells. Owns the cursor, the paint port and the clear sequencer. rgb follows x/y by 3 clocks.
// There is no backpressure: display reads never stall, and paint is ignored while the clear sequencer owns the write port.
module paint_canvas #(
    parameter int CELL_SHIFT = 2,
    parameter int CANVAS_W   = 160,
    parameter int CANVAS_H   = 120,
    parameter int ADDR_W     = 15,
    parameter int PIPE_LAT   = 3
) (
    input  logic        clk_100MHz,
    input  logic        reset_n,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        draw_en,
    input  logic        clear_req,
    input  logic [2:0]  color_sel,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        busy,
    output logic [7:0]  cursor_x,
    output logic [6:0]  cursor_y
);
    localparam int CELLS = CANVAS_W * CANVAS_H;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clear_addr;
    logic                r_busy;
    logic [7:0]          r_cur_x;
    logic [6:0]          r_cur_y;
    logic [2:0]          r_fb [0:CELLS-1];
    logic [ADDR_W-1:0]   r_s1_addr;
    logic                r_s1_vo, r_s1_hit;
    logic [2:0]          r_s2_idx;
    logic                r_s2_vo, r_s2_hit;
    logic [11:0]         r_rgb;
    logic [1:0]          r_sync_pipe [PIPE_LAT];

    logic [9:0]          w_cell_x, w_cell_y;
    logic [ADDR_W-1:0]   w_rd_addr, w_cur_addr, w_waddr;
    logic                w_hit, w_we;
    logic [2:0]          w_wdat;

    function automatic logic [11:0] f_palette(input logic [2:0] idx);
        case (idx)
            3'd0:    return 12'h000;
            3'd1:    return 12'hF00;
            3'd2:    return 12'h0F0;
            3'd3:    return 12'h00F;
            3'd4:    return 12'hFF0;
            3'd5:    return 12'h0FF;
            3'd6:    return 12'hF0F;
            default: return 12'hFFF;
        endcase
    endfunction

    assign w_cell_x   = x >> CELL_SHIFT;
    assign w_cell_y   = y >> CELL_SHIFT;
    assign w_rd_addr  = ADDR_W'(w_cell_y * CANVAS_W + w_cell_x);
    assign w_cur_addr = ADDR_W'(r_cur_y * CANVAS_W + r_cur_x);
    assign w_hit      = (w_cell_x == {2'b00, r_cur_x}) && (w_cell_y == {3'b000, r_cur_y});

    // Clear owns the write port outright; a clear request also suppresses that cycle's paint.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_cur_addr;
        w_wdat  = color_sel;
        if (r_state == S_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_clear_addr;
            w_wdat  = 3'd0;
        end else if (!clear_req && draw_en) begin
            w_we = 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (w_we)
            r_fb[w_waddr] <= w_wdat;
        r_s2_idx <= r_fb[r_s1_addr];
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_CLEAR;
            r_clear_addr <= '0;
            r_busy       <= 1'b1;
        end else if (r_state == S_IDLE) begin
            if (clear_req) begin
                r_state      <= S_CLEAR;
                r_clear_addr <= '0;
                r_busy       <= 1'b1;
            end
        end else begin
            if (r_clear_addr == ADDR_W'(CELLS - 1)) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                r_clear_addr <= r_clear_addr + 1'b1;
            end
        end
    end

    // Opposing strobes cancel; the cursor saturates at the canvas edges.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_cur_x <= 8'(CANVAS_W / 2);
            r_cur_y <= 7'(CANVAS_H / 2);
        end else begin
            if (btn_left && !btn_right && r_cur_x != 8'd0)
                r_cur_x <= r_cur_x - 1'b1;
            else if (btn_right && !btn_left && r_cur_x != 8'(CANVAS_W - 1))
                r_cur_x <= r_cur_x + 1'b1;
            if (btn_up && !btn_down && r_cur_y != 7'd0)
                r_cur_y <= r_cur_y - 1'b1;
            else if (btn_down && !btn_up && r_cur_y != 7'(CANVAS_H - 1))
                r_cur_y <= r_cur_y + 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_addr <= '0;
            r_s1_vo   <= 1'b0;
            r_s1_hit  <= 1'b0;
            r_s2_vo   <= 1'b0;
            r_s2_hit  <= 1'b0;
            r_rgb     <= 12'h000;
        end else begin
            r_s1_addr <= w_rd_addr;
            r_s1_vo   <= video_on;
            r_s1_hit  <= w_hit;
            r_s2_vo   <= r_s1_vo;
            r_s2_hit  <= r_s1_hit;
            r_rgb     <= r_s2_vo ? (f_palette(r_s2_idx) ^ {12{r_s2_hit}}) : 12'h000;
        end
    end

    // Inner sync stages reset low; only the output stage idles high toward the DAC.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PIPE_LAT; i++)
                r_sync_pipe[i] <= (i == PIPE_LAT - 1) ? 2'b11 : 2'b00;
        end else begin
            r_sync_pipe[0] <= {hsync_in, vsync_in};
            for (int i = 1; i < PIPE_LAT; i++)
                r_sync_pipe[i] <= r_sync_pipe[i-1];
        end
    end

    assign rgb       = r_rgb;
    assign hsync_out = r_sync_pipe[PIPE_LAT-1][1];
    assign vsync_out = r_sync_pipe[PIPE_LAT-1][0];
    assign busy      = r_busy;
    assign cursor_x  = r_cur_x;
    assign cursor_y  = r_cur_y;
endmodule

// File: tb/tb_paint_canvas.sv
// Bench for paint_canvas: a cell-array reference model with a per-cycle compare, plus directed literal checks.
module tb_paint_canvas;
    localparam int N = 19200;

    logic        clk_100MHz = 1'b0;
    logic        reset_n = 1'b0;
    logic        video_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
    logic [9:0]  x = '0, y = '0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic        draw_en = 1'b0, clear_req = 1'b0;
    logic [2:0]  color_sel = '0;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out, busy;
    logic [7:0]  cursor_x;
    logic [6:0]  cursor_y;

    paint_canvas dut (
        .clk_100MHz(clk_100MHz), .reset_n(reset_n), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .x(x), .y(y),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .draw_en(draw_en), .clear_req(clear_req), .color_sel(color_sel),
        .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out), .busy(busy),
        .cursor_x(cursor_x), .cursor_y(cursor_y)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int pal(input int i);
        case (i)
            0: return 'h000;
            1: return 'hF00;
            2: return 'h0F0;
            3: return 'h00F;
            4: return 'hFF0;
            5: return 'h0FF;
            6: return 'hF0F;
            default: return 'hFFF;
        endcase
    endfunction

    // Reference model: canvas as a plain array, clear as a countdown, and outputs as a 3-deep queue.
    typedef struct { int rgb; int hs; int vs; } exp_t;
    int   fb_m [N];
    int   m_cx = 80, m_cy = 60;
    bit   m_clearing = 1'b1;
    int   m_clr = 0;
    exp_t q [$];

    initial foreach (fb_m[i]) fb_m[i] = 0;

    always @(posedge clk_100MHz) begin : model
        int   cx, cy;
        bit   hit;
        exp_t e;
        if (!reset_n) begin
            m_cx = 80; m_cy = 60; m_clearing = 1'b1; m_clr = 0;
            q.delete();
        end else begin
            cx  = int'(x) / 4;
            cy  = int'(y) / 4;
            hit = (cx == m_cx) && (cy == m_cy);
            if (m_clearing) begin
                fb_m[m_clr] = 0;
                m_clr++;
                if (m_clr == N) m_clearing = 1'b0;
            end else if (clear_req) begin
                m_clearing = 1'b1;
                m_clr = 0;
            end else if (draw_en) begin
                fb_m[m_cy*160 + m_cx] = int'(color_sel);
            end
            e.rgb = video_on ? (pal(fb_m[cy*160 + cx]) ^ (hit ? 'hFFF : 0)) : 0;
            e.hs  = int'(hsync_in);
            e.vs  = int'(vsync_in);
            q.push_back(e);
            if (btn_left && !btn_right && m_cx > 0)    m_cx--;
            if (btn_right && !btn_left && m_cx < 159)  m_cx++;
            if (btn_up && !btn_down && m_cy > 0)       m_cy--;
            if (btn_down && !btn_up && m_cy < 119)     m_cy++;
        end
    end

    always @(negedge clk_100MHz) begin : compare
        exp_t e;
        if (!reset_n) begin
            check("rst_rgb", int'(rgb), 0);
            check("rst_hsync", int'(hsync_out), 1);
            check("rst_vsync", int'(vsync_out), 1);
            check("rst_busy", int'(busy), 1);
            check("rst_cursor", int'({cursor_x, cursor_y}), (80 << 7) | 60);
        end else begin
            check("busy", int'(busy), int'(m_clearing));
            check("cursor_x", int'(cursor_x), m_cx);
            check("cursor_y", int'(cursor_y), m_cy);
            if (q.size() == 3) begin
                e = q.pop_front();
                check("rgb", int'(rgb), e.rgb);
                check("hsync_out", int'(hsync_out), e.hs);
                check("vsync_out", int'(vsync_out), e.vs);
            end
        end
    end

    task automatic cyc();
        @(posedge clk_100MHz);
        #2;
    endtask

    task automatic probe(input int px, input int py, input bit vo, output int r);
        x = 10'(px); y = 10'(py); video_on = vo;
        repeat (3) cyc();
        r = int'(rgb);
        video_on = 1'b0;
    endtask

    task automatic wait_idle(input int n0, output int n);
        n = n0;
        do begin
            cyc();
            n++;
        end while (busy && n < 25000);
        draw_en = 1'b0;
    endtask

    task automatic move_to(input int tx, input int ty);
        for (int k = 0; k < 400 && (int'(cursor_x) != tx || int'(cursor_y) != ty); k++) begin
            btn_left  = int'(cursor_x) > tx;
            btn_right = int'(cursor_x) < tx;
            btn_up    = int'(cursor_y) > ty;
            btn_down  = int'(cursor_y) < ty;
            cyc();
        end
        {btn_left, btn_right, btn_up, btn_down} = 4'b0;
        check("move_to", int'({cursor_x, cursor_y}), (tx << 7) | ty);
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int r, n, t;
        repeat (3) cyc();
        reset_n = 1'b1;

        // Power-up clear and blank canvas
        wait_idle(0, n);
        check("t1_busy_len", n, 19200);
        probe(321, 242, 1, r); check("t1_cursor_cell", r, 'hFFF);
        probe(0, 0, 1, r);     check("t1_blank_0_0", r, 'h000);
        probe(639, 479, 1, r); check("t1_blank_corner", r, 'h000);

        // Cursor saturation and opposing strobes
        btn_left = 1'b1; repeat (100) cyc(); btn_left = 1'b0;
        check("t3_left_sat", int'(cursor_x), 0);
        btn_up = 1'b1; btn_down = 1'b1; cyc(); btn_up = 1'b0; btn_down = 1'b0;
        check("t3_updown", int'(cursor_y), 60);
        btn_right = 1'b1; repeat (159) cyc();
        check("t3_right_159", int'(cursor_x), 159);
        cyc(); btn_right = 1'b0;
        check("t3_right_sat", int'(cursor_x), 159);

        // Paint one cell, read it back, sync delay, blanking
        move_to(1, 0);
        color_sel = 3'd2; draw_en = 1'b1; cyc(); draw_en = 1'b0;
        move_to(5, 5);
        probe(4, 0, 1, r); check("t2_cell_1_0", r, 'h0F0);
        probe(7, 3, 1, r); check("t2_cell_1_0_far", r, 'h0F0);
        probe(4, 0, 0, r); check("t2_video_off", r, 'h000);
        hsync_in = 1'b0; cyc();
        cyc(); check("t2_hsync_2clk", int'(hsync_out), 1);
        cyc(); check("t2_hsync_3clk", int'(hsync_out), 0);
        hsync_in = 1'b1;

        // Cursor inversion over a painted cell
        move_to(0, 0);
        color_sel = 3'd1; draw_en = 1'b1; cyc(); draw_en = 1'b0;
        probe(0, 0, 1, r); check("t4_inv_0_0", r, 'h0FF);
        probe(3, 3, 1, r); check("t4_inv_3_3", r, 'h0FF);
        probe(4, 0, 1, r); check("t4_neighbour", r, 'h0F0);
        btn_right = 1'b1; cyc(); btn_right = 1'b0;
        probe(0, 0, 1, r); check("t4_uninv", r, 'hF00);

        // clear_req beats draw_en; draw_en during clear is ignored
        move_to(100, 100);
        color_sel = 3'd5; draw_en = 1'b1; cyc();
        color_sel = 3'd3; clear_req = 1'b1; cyc(); clear_req = 1'b0;
        color_sel = 3'd6;
        btn_left = 1'b1; cyc(); btn_left = 1'b0;
        probe(400, 400, 1, r); check("t5_no_write", r, 'h0FF);
        wait_idle(4, n);
        check("t5_busy_len", n, 19200);
        probe(400, 400, 1, r); check("t5_cleared", r, 'h000);
        probe(396, 401, 1, r); check("t5_cursor", r, 'hFFF);

        // Async reset in the middle of a clear
        x = 10'd396; y = 10'd400; video_on = 1'b1; hsync_in = 1'b0;
        clear_req = 1'b1; cyc(); clear_req = 1'b0;
        repeat (5000) cyc();
        check("t6_pre_rgb", int'(rgb), 'hFFF);
        reset_n = 1'b0;
        #1;
        check("t6_async_rgb", int'(rgb), 0);
        check("t6_async_hsync", int'(hsync_out), 1);
        check("t6_async_busy", int'(busy), 1);
        check("t6_async_cursor", int'({cursor_x, cursor_y}), (80 << 7) | 60);
        video_on = 1'b0; hsync_in = 1'b1;
        repeat (3) cyc();
        reset_n = 1'b1;
        wait_idle(0, n);
        check("t6_busy_len", n, 19200);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            btn_left  = ($urandom_range(0, 7) == 0);
            btn_right = ($urandom_range(0, 7) == 0);
            btn_up    = ($urandom_range(0, 7) == 0);
            btn_down  = ($urandom_range(0, 7) == 0);
            draw_en   = ($urandom_range(0, 2) == 0);
            color_sel = 3'($urandom_range(0, 7));
            video_on  = ($urandom_range(0, 3) != 0);
            hsync_in  = 1'($urandom_range(0, 1));
            vsync_in  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) begin
                x = 10'($urandom_range(0, 639));
                y = 10'($urandom_range(0, 479));
            end else begin
                t = m_cx * 4 + int'($urandom_range(0, 9)) - 3;
                x = 10'((t < 0) ? 0 : (t > 639) ? 639 : t);
                t = m_cy * 4 + int'($urandom_range(0, 9)) - 3;
                y = 10'((t < 0) ? 0 : (t > 479) ? 479 : t);
            end
            cyc();
        end
        {btn_left, btn_right, btn_up, btn_down, draw_en, video_on} = 6'b0;
        hsync_in = 1'b1; vsync_in = 1'b1;
        repeat (4) cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
